// File: rtl/de_scoreboard_pkg.sv
// Shared sizing constants for the decode-stage register scoreboard and the
// DE->FE control bundle layout.
package de_scoreboard_pkg;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_REG_IDX_W = 5;
  localparam int DEF_CNT_W     = 2;

  // DE->FE control bundle: stall_pipe occupies bit 0.
  localparam int FROM_DE_TO_FE_W   = 1;
  localparam int DE_FE_STALL_BIT   = 0;

  // Largest in-flight write count a CNT_W-bit tracker can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/de_scoreboard_counter.sv
// One per-register in-flight write tracker: saturating up/down counter that
// holds at zero on a stray decrement and flags it.
module sb_counter
  import de_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nonzero,
  output logic o_is_one,
  output logic o_is_max,
  output logic o_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_nonzero   = (r_cnt != '0);
  assign o_is_one    = (r_cnt == CNT_ONE);
  assign o_is_max    = (r_cnt == CNT_MAX);
  // A retire with nothing outstanding is an error even if an issue coincides.
  assign o_underflow = i_dec && (r_cnt == '0);

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writes per register,
// raises the DE->FE stall on RAW/WAW-full hazards and counts stalled cycles.
module de_scoreboard
  import de_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WB_BYPASS = 1,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REG_IDX_W-1:0] de_rs1,
  input  logic                 de_rs1_used,
  input  logic [REG_IDX_W-1:0] de_rs2,
  input  logic                 de_rs2_used,
  input  logic [REG_IDX_W-1:0] de_rd,
  input  logic                 de_wr_en,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_wr_en,
  output logic                 stall_pipe,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [PERF_W-1:0]    stall_cycles,
  output logic                 sb_err
);

  localparam bit BYPASS = (WB_BYPASS != 0);

  logic [NUM_REGS-1:0] w_nonzero;
  logic [NUM_REGS-1:0] w_is_one;
  logic [NUM_REGS-1:0] w_is_max;
  logic [NUM_REGS-1:0] w_underflow;
  logic [NUM_REGS-1:0] w_retire_hit;
  logic [NUM_REGS-1:0] w_inc;

  logic w_rs1_block;
  logic w_rs2_block;
  logic w_raw;
  logic w_waw_full;

  logic [PERF_W-1:0] r_stall_cycles;
  logic              r_sb_err;

  // x0 is never tracked: its slot is tied idle so every lookup of index 0
  // reads as not busy and never matches a retire.
  assign w_nonzero[0]    = 1'b0;
  assign w_is_one[0]     = 1'b0;
  assign w_is_max[0]     = 1'b0;
  assign w_underflow[0]  = 1'b0;
  assign w_retire_hit[0] = 1'b0;
  assign w_inc[0]        = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      assign w_retire_hit[gi] = wb_valid && wb_wr_en && (wb_rd == REG_IDX_W'(gi));
      assign w_inc[gi]        = issue && de_wr_en && (de_rd == REG_IDX_W'(gi));

      sb_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_inc[gi]),
        .i_dec       (w_retire_hit[gi]),
        .o_nonzero   (w_nonzero[gi]),
        .o_is_one    (w_is_one[gi]),
        .o_is_max    (w_is_max[gi]),
        .o_underflow (w_underflow[gi])
      );
    end
  endgenerate

  // A source whose last pending write is retiring this cycle is readable
  // through the write-through register file.
  always_comb begin
    w_rs1_block = w_nonzero[de_rs1] &&
                  !(BYPASS && w_retire_hit[de_rs1] && w_is_one[de_rs1]);
    w_rs2_block = w_nonzero[de_rs2] &&
                  !(BYPASS && w_retire_hit[de_rs2] && w_is_one[de_rs2]);
    w_raw       = (de_rs1_used && w_rs1_block) || (de_rs2_used && w_rs2_block);
    w_waw_full  = de_wr_en && w_is_max[de_rd] && !w_retire_hit[de_rd];
  end

  assign stall_pipe = !reset && de_valid && (w_raw || w_waw_full);
  assign issue      = !reset && de_valid && !stall_pipe && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_sb_err       <= 1'b0;
    end else begin
      if (de_valid && stall_pipe && !flush && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
      if (|w_underflow) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign busy_vec     = w_nonzero;
  assign stall_cycles = r_stall_cycles;
  assign sb_err       = r_sb_err;

endmodule

// File: tb/tb_de_scoreboard.sv
// Scoreboard bench for de_scoreboard: a driver pushes model-predicted outputs
// per cycle, a negedge monitor pops and compares them against the DUT.
module tb_de_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_rs1_used, de_rs2_used, de_wr_en, flush;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
  logic        wb_valid, wb_wr_en;
  logic        stall_pipe, issue, sb_err;
  logic [31:0] busy_vec, stall_cycles;

  always #5 clk = ~clk;

  de_scoreboard dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
    .de_rs2(de_rs2), .de_rs2_used(de_rs2_used), .de_rd(de_rd), .de_wr_en(de_wr_en),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
    .stall_pipe(stall_pipe), .issue(issue), .busy_vec(busy_vec),
    .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  typedef struct {
    int          id;
    logic        stall;
    logic        iss;
    logic [31:0] busy;
    logic [31:0] sc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  // Reference model: outstanding write count per register, perf counter, error flag.
  int          pend[32];
  longint      sc_m;
  bit          err_m;
  int          infl[$];

  function automatic bit src_blk(int s, bit ret_en, int ret_rd);
    return (s != 0) && (pend[s] > 0) && !(ret_en && ret_rd == s && pend[s] == 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit fl,
                      input bit wbv, input int wbrd, input bit wbwe, output bit issued);
    bit   ret_en, raw, waw, st, is;
    exp_t e;
    @(posedge clk); #1;
    de_valid = v; de_rs1 = rs1[4:0]; de_rs1_used = u1; de_rs2 = rs2[4:0]; de_rs2_used = u2;
    de_rd = rd[4:0]; de_wr_en = we; flush = fl;
    wb_valid = wbv; wb_rd = wbrd[4:0]; wb_wr_en = wbwe;
    ret_en = wbv && wbwe;
    raw = (u1 && src_blk(rs1, ret_en, wbrd)) || (u2 && src_blk(rs2, ret_en, wbrd));
    waw = we && rd != 0 && pend[rd] == 3 && !(ret_en && wbrd == rd);
    st  = v && (raw || waw);
    is  = v && !st && !fl;
    e.id = txn++; e.stall = st; e.iss = is; e.sc = sc_m[31:0]; e.err = err_m;
    e.busy = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (pend[r] != 0);
    exp_q.push_back(e);
    for (int r = 1; r < 32; r++) begin
      int i_r, d_r;
      i_r = (is && we && rd == r) ? 1 : 0;
      d_r = (ret_en && wbrd == r) ? 1 : 0;
      if (d_r == 1 && pend[r] == 0) err_m = 1'b1;
      else pend[r] = pend[r] + i_r - d_r;
    end
    if (v && st && !fl && sc_m < 64'hFFFF_FFFF) sc_m++;
    issued = is;
  endtask

  task automatic idle();
    bit d;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    de_valid = 0; de_rs1 = 0; de_rs1_used = 0; de_rs2 = 0; de_rs2_used = 0;
    de_rd = 0; de_wr_en = 0; flush = 0; wb_valid = 0; wb_rd = 0; wb_wr_en = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 32; r++) pend[r] = 0;
    sc_m = 0; err_m = 1'b0; infl.delete();
    probe();
    chk("rst_stall", {31'd0, stall_pipe}, 32'd0);
    chk("rst_issue", {31'd0, issue}, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err}, 32'd0);
  endtask

  // Monitor: pops one prediction per driven cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("txn %0d stall=%0b issue=%0b busy=%08h sc=%0d err=%0b",
               e.id, stall_pipe, issue, busy_vec, stall_cycles, sb_err);
      chk("mon_stall", {31'd0, stall_pipe}, {31'd0, e.stall});
      chk("mon_issue", {31'd0, issue}, {31'd0, e.iss});
      chk("mon_busy", busy_vec, e.busy);
      chk("mon_stall_cycles", stall_cycles, e.sc);
      chk("mon_sb_err", {31'd0, sb_err}, {31'd0, e.err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d;
    reset = 1'b1;
    do_reset();

    // RAW dependency resolved by a same-cycle bypassed retire.
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, d);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, d); probe();
    chk("raw_stall", {31'd0, stall_pipe}, 32'd1);
    chk("raw_busy5", {31'd0, busy_vec[5]}, 32'd1);
    step(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 1, d); probe();
    chk("bypass_stall", {31'd0, stall_pipe}, 32'd0);
    chk("bypass_issue", {31'd0, issue}, 32'd1);

    // x0 immunity.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, d);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, d); probe();
    chk("x0_stall", {31'd0, stall_pipe}, 32'd0);
    chk("x0_busy", busy_vec, 32'd0);

    // WAW saturation on x7.
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, d);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, d); probe();
    chk("waw_stall", {31'd0, stall_pipe}, 32'd1);
    step(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 1, d); probe();
    chk("waw_retire_issue", {31'd0, issue}, 32'd1);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, d); probe();
    chk("waw_still_full", {31'd0, stall_pipe}, 32'd1);

    // Flush squash.
    do_reset();
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, d); probe();
    chk("flush_issue", {31'd0, issue}, 32'd0);
    idle(); probe();
    chk("flush_busy9", {31'd0, busy_vec[9]}, 32'd0);

    // Simultaneous issue and retire on x3.
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, d);
    step(1, 0, 0, 0, 0, 3, 1, 0, 1, 3, 1, d); probe();
    chk("simul_issue", {31'd0, issue}, 32'd1);
    idle(); probe();
    chk("simul_busy3", {31'd0, busy_vec[3]}, 32'd1);

    // Underflow then perf count, then reset clears both.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, d);
    idle(); probe();
    chk("uf_err", {31'd0, sb_err}, 32'd1);
    chk("uf_busy4", {31'd0, busy_vec[4]}, 32'd0);
    idle(); probe();
    chk("uf_sticky", {31'd0, sb_err}, 32'd1);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, d);
    repeat (10) step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, d);
    idle(); probe();
    chk("perf_10", stall_cycles, 32'd10);
    do_reset();

    // Randomized traffic with a retire stream fed by the issued writes.
    for (int n = 0; n < 400; n++) begin
      bit v, u1, u2, we, fl, wbv, wbwe, is;
      int rs1, rs2, rd, wbrd;
      v = ($urandom_range(0, 99) < 80); fl = ($urandom_range(0, 99) < 8);
      rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1); we = ($urandom_range(0, 99) < 70);
      wbv = 0; wbwe = 0; wbrd = $urandom_range(0, 7);
      if (infl.size() > 0 && $urandom_range(0, 99) < 45) begin
        wbv = 1; wbwe = 1; wbrd = infl.pop_front();
      end else if ($urandom_range(0, 9) == 0) begin
        wbv = 1; wbwe = 0;
      end
      step(v, rs1, u1, rs2, u2, rd, we, fl, wbv, wbrd, wbwe, is);
      if (is && we) infl.push_back(rd);
    end
    idle();

    repeat (3) probe();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
